// File: rtl/trace_rx.sv
// rtl/trace_rx.sv - 8N1 serial trace receiver with byte FIFO and MMIO registers
// Offsets: 0 CR divisor, 1 SR flags (W1C bits 1/2), 3 RD pops the FIFO.
module trace_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        select_i,
  input  logic        rx_i,
  input  logic [3:0]  mem_wstrb_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  rx_state_t   state;
  logic [10:0] divisor;
  logic [10:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_meta, rx_sync, rx_prev;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic        overrun, framing_err;

  logic        expire, push, fe_set, do_push, ovr_set;
  logic        access, wr, pop, cr_wr, clr_ovr, clr_fe;
  logic [3:0]  off;
  logic [31:0] rdata_next;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr_i[31:6], mem_addr_i[1:0], mem_wdata_i[31:11]};

  assign expire = (cnt <= 11'd1);
  assign push   = (state == STOP) && expire && rx_sync;
  assign fe_set = (state == STOP) && expire && !rx_sync;

  assign access  = select_i && !mem_ready_o;
  assign wr      = |mem_wstrb_i;
  assign off     = mem_addr_i[5:2];
  assign pop     = access && !wr && (off == 4'd3) && (count != '0);
  assign cr_wr   = access && wr && (off == 4'd0);
  assign clr_ovr = access && wr && (off == 4'd1) && mem_wdata_i[1];
  assign clr_fe  = access && wr && (off == 4'd1) && mem_wdata_i[2];

  // A full FIFO still accepts a byte when a pop frees the slot on the same edge.
  assign do_push = push && ((count != FULL_CNT) || pop);
  assign ovr_set = push && !do_push;

  always_comb begin
    rdata_next = 32'h0;
    case (off)
      4'd0: rdata_next = {21'h0, divisor};
      4'd1: rdata_next = {28'h0, (count == FULL_CNT), framing_err, overrun, (count != '0)};
      4'd3: if (count != '0) rdata_next = {24'h0, fifo_mem[rptr]};
      default: rdata_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: if (rx_prev && !rx_sync && divisor >= 11'd4) begin
          state <= START;
          cnt   <= divisor >> 1;
        end
        START: begin
          if (!expire) cnt <= cnt - 11'd1;
          else if (!rx_sync) begin
            state   <= DATA;
            cnt     <= divisor;
            bit_idx <= '0;
          end else state <= IDLE;
        end
        DATA: begin
          if (!expire) cnt <= cnt - 11'd1;
          else begin
            shreg   <= {rx_sync, shreg[7:1]};
            cnt     <= divisor;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!expire) cnt <= cnt - 11'd1;
          else state <= rx_sync ? IDLE : BREAK;
        end
        BREAK: if (rx_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) fifo_mem[wptr] <= shreg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      divisor     <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;

      // Hardware set takes priority over a coincident W1C clear.
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
      if (fe_set)       framing_err <= 1'b1;
      else if (clr_fe)  framing_err <= 1'b0;

      if (cr_wr) divisor <= mem_wdata_i[10:0];

      mem_ready_o <= access;
      if (access) mem_rdata_o <= rdata_next;
    end
  end

endmodule
